mf8_ifetch: RTL



---
 rtl/mf8_pkg.sv | 33 +++
 rtl/mf8_brdec.sv | 45 ++++
 rtl/mf8_ifetch.sv | 127 ++++++++++++
 3 files changed

// File: rtl/mf8_pkg.sv
// mf8_pkg: shared types and constants for the mf8 fetch / flow-control stage.
//   - ifetch_state_e : fetch FSM states
//   - opcode match masks/values for RJMP, RCALL, BRBS, BRBC
//   - NOP word and bubble counts per jump class
package mf8_pkg;

    localparam int unsigned INST_W = 16;
    localparam int unsigned SREG_W = 8;
    localparam int unsigned BCNT_W = 2;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_EXEC   = 2'd1,
        ST_BUBBLE = 2'd2,
        ST_SQUASH = 2'd3
    } ifetch_state_e;

    localparam logic [INST_W-1:0] RJMP_MASK  = 16'hF000;
    localparam logic [INST_W-1:0] RJMP_VAL   = 16'hC000;
    localparam logic [INST_W-1:0] RCALL_MASK = 16'hF000;
    localparam logic [INST_W-1:0] RCALL_VAL  = 16'hD000;
    localparam logic [INST_W-1:0] BRBS_MASK  = 16'hFC00;
    localparam logic [INST_W-1:0] BRBS_VAL   = 16'hF000;
    localparam logic [INST_W-1:0] BRBC_MASK  = 16'hFC00;
    localparam logic [INST_W-1:0] BRBC_VAL   = 16'hF400;

    localparam logic [INST_W-1:0] NOP = 16'h0000;

    localparam logic [BCNT_W-1:0] BUB_RJMP   = 2'd1;
    localparam logic [BCNT_W-1:0] BUB_RCALL  = 2'd2;
    localparam logic [BCNT_W-1:0] BUB_BRANCH = 2'd1;

endpackage

// File: rtl/mf8_brdec.sv
// mf8_brdec: combinational relative-jump / call / conditional-branch decoder.
// Ports:
//   rom_data  in   16        instruction word
//   sreg      in   8         status flags for BRBS/BRBC
//   is_jump   out  1         word redirects the PC
//   offset    out  PC_WIDTH  PC increment for the redirect (k+1, modulo 2^PC_WIDTH)
//   bubbles   out  2         dead cycles the jump costs in the cycle-accurate build
module mf8_brdec
    import mf8_pkg::*;
#(
    parameter int unsigned PC_WIDTH = 12
) (
    input  logic [INST_W-1:0]   rom_data,
    input  logic [SREG_W-1:0]   sreg,
    output logic                is_jump,
    output logic [PC_WIDTH-1:0] offset,
    output logic [BCNT_W-1:0]   bubbles
);

    logic flag;

    assign flag = sreg[rom_data[2:0]];

    // Priority decode; +1 because the sequencer adds the offset to the jump's own PC.
    always_comb begin
        is_jump = 1'b0;
        offset  = '0;
        bubbles = '0;
        if ((rom_data & RJMP_MASK) == RJMP_VAL) begin
            is_jump = 1'b1;
            offset  = PC_WIDTH'($signed(rom_data[11:0])) + PC_WIDTH'(1);
            bubbles = BUB_RJMP;
        end else if ((rom_data & RCALL_MASK) == RCALL_VAL) begin
            is_jump = 1'b1;
            offset  = PC_WIDTH'($signed(rom_data[11:0])) + PC_WIDTH'(1);
            bubbles = BUB_RCALL;
        end else if (((rom_data & BRBS_MASK) == BRBS_VAL && flag) ||
                     ((rom_data & BRBC_MASK) == BRBC_VAL && !flag)) begin
            is_jump = 1'b1;
            offset  = PC_WIDTH'($signed(rom_data[9:3])) + PC_WIDTH'(1);
            bubbles = BUB_BRANCH;
        end
    end

endmodule

// File: rtl/mf8_ifetch.sv
// mf8_ifetch: instruction fetch and flow-control stage of the mf8 core.
// Optional feature macro: MF8_IFETCH_CYCLE_ACCURATE_EN (jump bubbles with AVR timing).
// Ports:
//   Clk, Reset      clock, synchronous active-high reset
//   ROM_Data  in    word at the current PC (ROM has one-cycle latency from NPC)
//   SREG      in    status flags for branch evaluation
//   Stall_In  in    datapath holds the current instruction
//   Skip_In   in    current instruction resolved to skip the next word
//   Inst      out   instruction to datapath, NOP when not valid
//   Inst_Valid out  Inst is a real instruction
//   Offs_Out  out   jump offset to the sequencer (0 unless RJmp)
//   RJmp      out   sequencer uses Offs_Out as PC increment
//   Pause     out   sequencer holds the PC
// Outputs are combinational from state, ROM_Data and SREG so the sequencer can act the same cycle.
module mf8_ifetch
    import mf8_pkg::*;
#(
    parameter int unsigned PC_WIDTH = 12
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [INST_W-1:0]   ROM_Data,
    input  logic [SREG_W-1:0]   SREG,
    input  logic                Stall_In,
    input  logic                Skip_In,
    output logic [INST_W-1:0]   Inst,
    output logic                Inst_Valid,
    output logic [PC_WIDTH-1:0] Offs_Out,
    output logic                RJmp,
    output logic                Pause
);

    ifetch_state_e       state;
    ifetch_state_e       state_nxt;
    logic                dec_jump;
    logic [PC_WIDTH-1:0] dec_offset;
    logic [BCNT_W-1:0]   dec_bubbles;

    mf8_brdec #(.PC_WIDTH(PC_WIDTH)) u_brdec (
        .rom_data (ROM_Data),
        .sreg     (SREG),
        .is_jump  (dec_jump),
        .offset   (dec_offset),
        .bubbles  (dec_bubbles)
    );

`ifdef MF8_IFETCH_CYCLE_ACCURATE_EN
    logic [BCNT_W-1:0] bcnt;
    logic [BCNT_W-1:0] bcnt_nxt;

    // State register and bubble counter.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= ST_BOOT;
            bcnt  <= '0;
        end else begin
            state <= state_nxt;
            bcnt  <= bcnt_nxt;
        end
    end
`else
    // Without bubbles the jump class cost is irrelevant.
    logic unused_bubbles;
    assign unused_bubbles = ^dec_bubbles;

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= ST_BOOT;
        end else begin
            state <= state_nxt;
        end
    end
`endif

    // Next-state and output decode.
    always_comb begin
        state_nxt  = state;
`ifdef MF8_IFETCH_CYCLE_ACCURATE_EN
        bcnt_nxt   = bcnt;
`endif
        Inst       = NOP;
        Inst_Valid = 1'b0;
        Offs_Out   = '0;
        RJmp       = 1'b0;
        Pause      = 1'b1;
        case (state)
            // One held cycle lets the ROM return address 0.
            ST_BOOT: state_nxt = ST_EXEC;
            ST_EXEC: begin
                Inst       = ROM_Data;
                Inst_Valid = 1'b1;
                if (!Stall_In) begin
                    Pause = 1'b0;
                    // A jump wins over a simultaneous skip.
                    if (dec_jump) begin
                        RJmp     = 1'b1;
                        Offs_Out = dec_offset;
`ifdef MF8_IFETCH_CYCLE_ACCURATE_EN
                        state_nxt = ST_BUBBLE;
                        bcnt_nxt  = dec_bubbles;
`endif
                    end else if (Skip_In) begin
                        state_nxt = ST_SQUASH;
                    end
                end
            end
            ST_BUBBLE: begin
`ifdef MF8_IFETCH_CYCLE_ACCURATE_EN
                bcnt_nxt = bcnt - 2'd1;
                if (bcnt <= 2'd1) begin
                    state_nxt = ST_EXEC;
                end
`else
                state_nxt = ST_EXEC;
`endif
            end
            // Skipped word is fetched but not executed; PC moves past it.
            ST_SQUASH: begin
                Pause     = 1'b0;
                state_nxt = ST_EXEC;
            end
            default: state_nxt = ST_BOOT;
        endcase
    end

endmodule
